// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback arbiter
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XZR_IDX = 31;
  localparam int DATA_W = 64;
  typedef enum logic {INIT, RUN} wb_state_t;
  typedef enum logic {GNT_A, GNT_B} wb_src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester handshakes, stall and register-file write port
interface regfile_wb_arbiter_if #(parameter int DATA_W = 64);
  import regfile_pkg::*;
  logic stall;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [REG_ADDR_W-1:0] a_addr, b_addr, wa3;
  logic [DATA_W-1:0] a_data, b_data, wd3;
  logic we3, init_done;
  modport slave(
    input stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we3, wa3, wd3, init_done
  );
  modport master(
    output stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input a_ready, b_ready, we3, wa3, wd3, init_done
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way writeback grant; WB_ARB_FIXED_PRIO_EN makes B win every tie
module rr_arbiter2 import regfile_pkg::*; (
  input  logic    a_valid,
  input  logic    b_valid,
  input  wb_src_t last_grant,
  output logic    gnt_a,
  output logic    gnt_b
);
`ifdef WB_ARB_FIXED_PRIO_EN
  assign gnt_b = b_valid;
  assign gnt_a = a_valid & ~b_valid;
`else
  assign gnt_a = a_valid & (~b_valid | (last_grant == GNT_B));
  assign gnt_b = b_valid & (~a_valid | (last_grant == GNT_A));
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: self-initialises the register file, then arbitrates A/B writebacks
// onto a registered write port (tie policy selected by WB_ARB_FIXED_PRIO_EN)
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREGS = 32,
  parameter int INIT_ON_RESET = 1
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_pkg::*;
  localparam int CW = $clog2(NREGS);
  wb_state_t state, state_n;
  wb_src_t last_grant, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic out_v, out_v_n;
  logic [REG_ADDR_W-1:0] out_addr, out_addr_n;
  logic [DATA_W-1:0] out_data, out_data_n;
  logic gnt_a, gnt_b;
  rr_arbiter2 u_arb (
    .a_valid(bus.a_valid),
    .b_valid(bus.b_valid),
    .last_grant(last_grant),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= (INIT_ON_RESET != 0) ? INIT : RUN;
      cnt <= '0;
      out_v <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      last_grant <= GNT_B;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_v <= out_v_n;
      out_addr <= out_addr_n;
      out_data <= out_data_n;
      last_grant <= last_n;
    end
  end
  // stall freezes everything; otherwise the output register reloads each cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    out_v_n = out_v;
    out_addr_n = out_addr;
    out_data_n = out_data;
    last_n = last_grant;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    if (!bus.stall) begin
      out_v_n = 1'b0;
      if (state == INIT) begin
        out_v_n = 1'b1;
        out_addr_n = REG_ADDR_W'(cnt);
        out_data_n = DATA_W'(cnt);
        cnt_n = cnt + 1'b1;
        state_n = (cnt == CW'(NREGS - 2)) ? RUN : INIT;
      end else begin
        bus.a_ready = gnt_a;
        bus.b_ready = gnt_b;
        if (gnt_a | gnt_b) begin
          out_addr_n = gnt_a ? bus.a_addr : bus.b_addr;
          out_data_n = gnt_a ? bus.a_data : bus.b_data;
          out_v_n = out_addr_n != REG_ADDR_W'(XZR_IDX);
          last_n = gnt_a ? GNT_A : GNT_B;
        end
      end
    end
  end
  assign bus.we3 = out_v & ~bus.stall;
  assign bus.wa3 = out_addr;
  assign bus.wd3 = out_data;
  assign bus.init_done = state == RUN;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized self-checking bench with a behavioural writeback model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  regfile_wb_arbiter_if #(.DATA_W(64)) bus();
  regfile_wb_arbiter #(.DATA_W(64), .NREGS(32), .INIT_ON_RESET(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [63:0] rf [32] = '{default: 64'd0};
  always @(posedge clk) if (bus.we3) rf[bus.wa3] <= bus.wd3;
  logic [63:0] m_rf [32];
  bit m_run, m_last_b, m_pv;
  logic [4:0] m_pa;
  logic [63:0] m_pd;
  int m_cnt;
  logic exp_ar, exp_br, exp_we;
  logic [4:0] exp_wa;
  logic [63:0] exp_wd;
  task automatic model_reset();
    m_run = 0;
    m_cnt = 0;
    m_pv = 0;
    m_pa = '0;
    m_pd = '0;
    m_last_b = 1;
  endtask
  task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [63:0] bd, input logic st);
    bit pick_a;
    bus.a_valid = av;
    bus.a_addr = aa;
    bus.a_data = ad;
    bus.b_valid = bv;
    bus.b_addr = ba;
    bus.b_data = bd;
    bus.stall = st;
    exp_we = m_pv && !st;
    exp_wa = m_pa;
    exp_wd = m_pd;
`ifdef WB_ARB_FIXED_PRIO_EN
    pick_a = av && !bv;
`else
    pick_a = av && (!bv || m_last_b);
`endif
    exp_ar = m_run && !st && pick_a;
    exp_br = m_run && !st && bv && !pick_a;
    @(negedge clk);
  endtask
  task automatic idle(input logic st);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, st);
  endtask
  task automatic advance();
    @(posedge clk);
    if (exp_we) m_rf[exp_wa] = exp_wd;
    if (!bus.stall) begin
      if (!m_run) begin
        m_pv = 1;
        m_pa = 5'(m_cnt);
        m_pd = 64'(m_cnt);
        m_cnt++;
        m_run = (m_cnt == 31);
      end else if (exp_ar) begin
        m_pv = bus.a_addr != 5'd31;
        m_pa = bus.a_addr;
        m_pd = bus.a_data;
        m_last_b = 0;
      end else if (exp_br) begin
        m_pv = bus.b_addr != 5'd31;
        m_pa = bus.b_addr;
        m_pd = bus.b_data;
        m_last_b = 1;
      end else m_pv = 0;
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step(1'b1, 5'd3, 64'd3, 1'b1, 5'd2, 64'd2, 1'b0);
    checks++; if (bus.we3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b want=0", bus.we3); end
    checks++; if (bus.wa3 !== 5'd0) begin failures++; $display("FAIL reset_wa3 got=%0d want=0", bus.wa3); end
    checks++; if (bus.wd3 !== 64'd0) begin failures++; $display("FAIL reset_wd3 got=%h want=0", bus.wd3); end
    checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b want=00", bus.a_ready, bus.b_ready); end
    checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", bus.init_done); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic test_init();
    int nw = 0;
    for (int i = 0; i < 33; i++) begin
      idle(1'b0);
      checks++; if (bus.we3 !== exp_we) begin failures++; $display("FAIL init_we3 i=%0d got=%b want=%b", i, bus.we3, exp_we); end
      if (exp_we) begin
        checks++; if (bus.wa3 !== exp_wa || bus.wd3 !== exp_wd) begin failures++; $display("FAIL init_write i=%0d got=%0d/%h want=%0d/%h", i, bus.wa3, bus.wd3, exp_wa, exp_wd); end
      end
      checks++; if (bus.init_done !== m_run) begin failures++; $display("FAIL init_done i=%0d got=%b want=%b", i, bus.init_done, m_run); end
      nw += int'(bus.we3);
      advance();
    end
    checks++; if (nw != 31) begin failures++; $display("FAIL init_count got=%0d want=31", nw); end
    checks++; if (bus.init_done !== 1'b1) begin failures++; $display("FAIL init_done_final got=%b want=1", bus.init_done); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (rf[i] !== m_rf[i]) begin failures++; $display("FAIL init_rf reg=%0d got=%h want=%h", i, rf[i], m_rf[i]); end
    end
    checks++; if (rf[30] !== 64'd30 || rf[31] !== 64'd0) begin failures++; $display("FAIL init_rf_edge got=%h/%h want=1e/0", rf[30], rf[31]); end
  endtask
  task automatic test_alternate();
    logic want_a;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd5, 64'h5, 1'b1, 5'd6, 64'h6, 1'b0);
`ifdef WB_ARB_FIXED_PRIO_EN
      want_a = 1'b0;
`else
      want_a = (i % 2) == 0;
`endif
      checks++; if (bus.a_ready !== want_a || bus.b_ready !== !want_a) begin failures++; $display("FAIL alt_grant i=%0d got=%b%b want=%b%b", i, bus.a_ready, bus.b_ready, want_a, !want_a); end
      checks++; if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br) begin failures++; $display("FAIL alt_model i=%0d got=%b%b want=%b%b", i, bus.a_ready, bus.b_ready, exp_ar, exp_br); end
      if (i > 0) begin
        checks++; if (bus.we3 !== exp_we || bus.wa3 !== exp_wa || bus.wd3 !== exp_wd) begin failures++; $display("FAIL alt_write i=%0d got=%b/%0d/%h want=%b/%0d/%h", i, bus.we3, bus.wa3, bus.wd3, exp_we, exp_wa, exp_wd); end
      end
      advance();
    end
    idle(1'b0);
    advance();
    idle(1'b0);
    advance();
    checks++; if (rf[5] !== m_rf[5] || rf[6] !== m_rf[6]) begin failures++; $display("FAIL alt_rf got=%h/%h want=%h/%h", rf[5], rf[6], m_rf[5], m_rf[6]); end
  endtask
  task automatic test_a_only();
    step(1'b1, 5'd4, 64'hFFF, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL a_only_ready got=%b%b want=10", bus.a_ready, bus.b_ready); end
    advance();
    idle(1'b0);
    checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd4 || bus.wd3 !== 64'hFFF) begin failures++; $display("FAIL a_only_write got=%b/%0d/%h want=1/4/fff", bus.we3, bus.wa3, bus.wd3); end
    advance();
    checks++; if (rf[4] !== 64'hFFF) begin failures++; $display("FAIL a_only_rf got=%h want=fff", rf[4]); end
  endtask
  task automatic test_xzr();
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, {64{1'b1}}, 1'b0);
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL xzr_ready got=%b want=1", bus.b_ready); end
    advance();
    idle(1'b0);
    checks++; if (bus.we3 !== 1'b0) begin failures++; $display("FAIL xzr_we3 got=%b want=0", bus.we3); end
    advance();
    checks++; if (rf[31] !== 64'd0) begin failures++; $display("FAIL xzr_rf got=%h want=0", rf[31]); end
  endtask
  task automatic test_stall();
    int nw = 0;
    step(1'b1, 5'd7, 64'h123456789ABCDEF0, 1'b0, 5'd0, 64'd0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA, 1'b1);
      checks++; if (bus.we3 !== 1'b0 || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL stall_quiet i=%0d got=%b%b%b want=000", i, bus.we3, bus.a_ready, bus.b_ready); end
      checks++; if (bus.wa3 !== 5'd7 || bus.wd3 !== 64'h123456789ABCDEF0) begin failures++; $display("FAIL stall_hold i=%0d got=%0d/%h want=7/123456789abcdef0", i, bus.wa3, bus.wd3); end
      nw += int'(bus.we3);
      advance();
    end
    idle(1'b0);
    checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd7) begin failures++; $display("FAIL stall_release got=%b/%0d want=1/7", bus.we3, bus.wa3); end
    nw += int'(bus.we3);
    advance();
    idle(1'b0);
    nw += int'(bus.we3);
    advance();
    checks++; if (nw != 1 || rf[7] !== 64'h123456789ABCDEF0) begin failures++; $display("FAIL stall_rf writes=%0d got=%h want=1/123456789abcdef0", nw, rf[7]); end
  endtask
  task automatic test_random();
    bit av = 0, bv = 0, st;
    logic [4:0] aa = '0, ba = '0;
    logic [63:0] ad = '0, bd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!av && $urandom_range(0, 2) != 0) begin
        av = 1;
        aa = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        ad = {$urandom, $urandom};
      end
      if (!bv && $urandom_range(0, 2) != 0) begin
        bv = 1;
        ba = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        bd = {$urandom, $urandom};
      end
      st = $urandom_range(0, 4) == 0;
      step(av, aa, ad, bv, ba, bd, st);
      checks++; if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br) begin failures++; $display("FAIL rand_ready n=%0d got=%b%b want=%b%b", n, bus.a_ready, bus.b_ready, exp_ar, exp_br); end
      checks++; if (bus.we3 !== exp_we) begin failures++; $display("FAIL rand_we3 n=%0d got=%b want=%b", n, bus.we3, exp_we); end
      if (exp_we) begin
        checks++; if (bus.wa3 !== exp_wa || bus.wd3 !== exp_wd) begin failures++; $display("FAIL rand_write n=%0d got=%0d/%h want=%0d/%h", n, bus.wa3, bus.wd3, exp_wa, exp_wd); end
      end
      advance();
      if (exp_ar) av = 0;
      if (exp_br) bv = 0;
    end
    idle(1'b0);
    advance();
    idle(1'b0);
    advance();
    for (int i = 0; i < 32; i++) begin
      checks++; if (rf[i] !== m_rf[i]) begin failures++; $display("FAIL rand_rf reg=%0d got=%h want=%h", i, rf[i], m_rf[i]); end
    end
  endtask
  task automatic test_reset_mid_init();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    while (m_cnt < 10) begin
      idle(1'b0);
      advance();
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.we3 !== 1'b0 || bus.wa3 !== 5'd0 || bus.wd3 !== 64'd0 || bus.init_done !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b/%0d/%h/%b want=0/0/0/0", bus.we3, bus.wa3, bus.wd3, bus.init_done); end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1'b0);
    checks++; if (bus.we3 !== 1'b0) begin failures++; $display("FAIL midreset_first got=%b want=0", bus.we3); end
    advance();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'(i) || bus.wd3 !== 64'(i)) begin failures++; $display("FAIL midreset_restart i=%0d got=%b/%0d/%h want=1/%0d/%0d", i, bus.we3, bus.wa3, bus.wd3, i, i); end
      advance();
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    test_reset();
    test_init();
    test_alternate();
    test_a_only();
    test_xzr();
    test_stall();
    test_random();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 32x64 register file.
- After reset, sequences a self-initialisation pass that writes reg i = i for i = 0..30.
- Then arbitrates between two writeback requesters, A (ALU/EX result) and B (memory load result), using valid/ready handshakes.
- The write port is registered with 1-cycle latency. An external stall freezes it.

Parameters:
- DATA_W, 64, register data width.
- NREGS, 32, number of architectural registers; index NREGS-1 is XZR.
- INIT_ON_RESET, 1, 1 = run the INIT pass after reset; 0 = start directly in RUN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the write port; no acceptance, no write.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  5  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  5  B destination register.
- b_data  in  DATA_W  B write data.
- we3  out  1  register file write enable.
- wa3  out  5  register file write address.
- wd3  out  DATA_W  register file write data.
- init_done  out  1  high once the INIT pass is complete.

Behaviour:
- Reset (async, any time, including mid-INIT or mid-write):
  - state = INIT (RUN if INIT_ON_RESET = 0), cnt = 0, out_v = 0, out_addr = 0, out_data = 0, last_grant = B.
  - Outputs: we3 = 0, wa3 = 0, wd3 = 0, a_ready = 0, b_ready = 0, init_done = 0 (1 if INIT_ON_RESET = 0).
  - Any pending write is discarded.
- Output register (out_v, out_addr, out_data):
  - we3 = out_v & ~stall; wa3 = out_addr; wd3 = out_data (combinational from the register).
  - stall = 1: the register holds and cnt holds.
  - stall = 0: the register reloads every cycle. out_v = 0 if nothing is issued that cycle.
- State INIT:
  - a_ready = b_ready = 0.
  - Each non-stalled cycle loads out_v = 1, out_addr = cnt, out_data = zero-extended cnt, then cnt++.
  - Loading cnt = NREGS-2 (30) transitions to RUN. XZR is never written.
  - Total: 31 writes, first we3 in the cycle after reset deassertion.
- State RUN:
  - init_done = 1.
  - Grant is combinational:
    - Only A valid: A.
    - Only B valid: B.
    - Both valid: the requester that is not last_grant.
  - x_ready = grant_x & ~stall & (state == RUN).
  - Accept on x_valid & x_ready at posedge:
    - out_v = (x_addr != 31), out_addr = x_addr, out_data = x_data.
    - last_grant = x.
  - A write to XZR is accepted (ready = 1, handshake completes) but dropped: we3 stays 0 next cycle.
- Latency: accept at posedge t, we3 high during cycle t+1, register file captures at posedge t+1.
- Throughput: 1 write per non-stalled cycle. The loser's valid must stay high with stable addr/data until accepted.
- Two same-address writes in consecutive cycles: both go out in acceptance order; the last accepted wins.
- last_grant is unchanged on cycles with no accept, including stall cycles.
- RUN is terminal until reset.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, B always wins when both are valid. last_grant is still tracked but ignored.
- Undefined: round-robin as above.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W = 5, XZR_IDX = 31, DATA_W default 64.
  - typedef enum logic {INIT, RUN} wb_state_t.
  - typedef enum logic {GNT_A, GNT_B} wb_src_t.
- Sub-module rr_arbiter2 (2-way grant logic with last_grant input; honours WB_ARB_FIXED_PRIO_EN). The FSM, counter and output register stay in the top module.

Test Plan:
- INIT: release reset, stall = 0 -> 31 consecutive cycles with we3 = 1, wa3/wd3 = 0..30; then we3 = 0 and init_done = 1; bench regfile reads reg i = i, reg 31 = 0.
- A only: a_addr = 4, a_data = 64'hFFF -> a_ready = 1; next cycle we3 = 1, wa3 = 4, wd3 = 64'hFFF; read of reg 4 returns 64'hFFF.
- Both valid for 4 cycles, A -> reg 5 / 64'h5, B -> reg 6 / 64'h6, handshakes honoured -> grants alternate A, B, A, B from reset; with WB_ARB_FIXED_PRIO_EN, B every cycle.
- XZR: b_addr = 31, b_data = all-ones -> b_ready = 1; next cycle we3 = 0; reg 31 reads 0.
- Stall: accept A (reg 7 / 64'h123456789ABCDEF0), then stall = 1 for 3 cycles -> we3 = 0, a_ready = b_ready = 0, wa3/wd3 held; stall = 0 -> one write to reg 7.
- Reset mid-INIT at cnt = 10 -> all outputs 0 immediately; after release, INIT restarts at wa3 = 0.
